fetch_unit_nw: RTL
==================

// Module: fetch_unit_nw
// PURPOSE
//  Parametrised N-wide instruction fetch stage for the OOO-OTTER front end.
//  - Holds the PC and issues one FETCH_WIDTH-word group request per cycle to instruction memory.
//  - Buffers returned {pc, instr} bundles in a fetch queue; decode drains it over a valid/ready handshake.
//  - Handles jalr/branch/jump redirects with flush, and load-hazard stalls.
// PARAMETERS
//  FETCH_WIDTH   2        instructions per fetch group (1..4)
//  QUEUE_DEPTH   4        fetch-queue entries, in bundles (power of 2, >=2)
//  RESET_PC      32'h0    PC loaded on reset
// PORTS
//  CLK          in   1               clock
//  EXT_RESET    in   1               synchronous, active-high reset
//  jalr_pc      in   32              jalr target
//  branch_pc    in   32              branch target
//  jump_pc      in   32              jal target
//  pc_source    in   2               pc_src_t; PC_NEXT=0 means no redirect
//  ld_haz       in   1               load-use stall; blocks new requests
//  imem_req     out  1               request strobe to instruction memory
//  imem_addr    out  32              byte address of group lane 0
//  imem_rdata   in   32*FETCH_WIDTH  group words, valid exactly 1 cycle after imem_req
//  dec_valid    out  1               queue head bundle valid
//  dec_ready    in   1               decode accepts head bundle
//  dec_pc       out  32*FETCH_WIDTH  lane i PC in bits [32i+:32]
//  dec_instr    out  32*FETCH_WIDTH  lane i instruction in bits [32i+:32]
//  queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Clock and reset: single clock CLK; reset EXT_RESET is synchronous, active-high.
//  - Reset outputs: pc_q=RESET_PC; queue empty; no response pending; imem_req=0; dec_valid=0;
//    queue_count=0; dec_pc/dec_instr=0.
//  - Issue condition: imem_req = !EXT_RESET && !redirect && !ld_haz && (queue_count + rsp_pending < QUEUE_DEPTH).
//  - On issue: imem_addr=pc_q; pc_q <= pc_q + 4*FETCH_WIDTH (32-bit wrap); rsp_pending <= 1.
//  - Response: in the cycle after an issue, when rsp_pending and not killed,
//    push {pc[i]=addr+4i, instr[i]=imem_rdata lane i} at the clock edge.
//  - Decode visibility: bundle is visible on dec_valid the next cycle.
//    Request-to-dec_valid latency is 2 cycles.
//  - Pop: head dequeues on dec_valid && dec_ready. dec_* is driven from registered head storage.
//  - Push and pop in the same cycle are both honoured; count is unchanged.
//  - Overflow: credit gating (count + pending) makes overflow impossible. Assert no push when full.
//  - Redirect (pc_source != PC_NEXT), in priority order:
//    1. pc_q <= selected target with bits[1:0] forced to 0.
//    2. Queue flushed: count <= 0, dec_valid=0 next cycle.
//    3. The pending response is killed, i.e. not pushed.
//    4. No request is issued that cycle.
//  - Redirect timing: first request to the target at t+1; bundle on dec_valid at t+3.
//  - Redirect has priority over ld_haz and over a same-cycle dec_ready pop; the pop is discarded by the flush.
//  - ld_haz: holds pc_q and blocks issue. An in-flight response is still pushed. Decode handshake is unaffected.
//  - Reset mid-operation: all state returns to reset values on the next edge; an in-flight response is dropped.
//  - Unaligned groups: groups need not be naturally aligned; memory returns FETCH_WIDTH words from imem_addr.
// CONFIGURATION
//  - Macro FETCH_PERF_EN, when defined, adds output ports perf_bundles, perf_stall_cycles and perf_flushes (32 bits each):
//    - perf_bundles counts pushes.
//    - perf_stall_cycles counts cycles with ld_haz=1, or with issue blocked by credits while not in reset.
//    - perf_flushes counts redirect cycles.
//    - All three reset to 0 on EXT_RESET and wrap at 2^32.
//  - Without FETCH_PERF_EN: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package fetch_pkg:
//    - pc_src_t enum: PC_NEXT=0, PC_JALR=1, PC_BRANCH=2, PC_JUMP=3.
//    - fetch_bundle_t struct: pc[FETCH_WIDTH], instr[FETCH_WIDTH].
//    - Constant INSTR_BYTES=4.
//  - Sub-module fetch_queue: parametrised circular FIFO with push, pop, flush and count.
//    Pointers wrap modulo QUEUE_DEPTH.
//  - Top level keeps the PC register, the target mux, credit logic, pending/kill flag and the optional perf counters.
// TESTING
//  1. Reset, RESET_PC=0, FETCH_WIDTH=2, dec_ready=1 -> imem_addr 0,8,16...; first dec_valid 2 cycles after first req;
//     dec_pc={4,0}.
//  2. dec_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> exactly 4 requests issued; queue_count=4; imem_req=0 after.
//     Release -> draining resumes in order with no loss or duplication.
//  3. pc_source=PC_BRANCH, branch_pc=32'h103 at cycle t while a response is pending ->
//     pending bundle not pushed; queue_count=0 at t+1; imem_addr=32'h100 at t+1; dec_pc lane0=32'h100 at t+3.
//  4. ld_haz=1 for 3 cycles with pc_q=32'h40 -> no imem_req, pc_q held.
//     The in-flight bundle (pc 32'h38) is still pushed; fetch resumes at 32'h40.
//  5. EXT_RESET asserted with 3 bundles queued and 1 pending -> next cycle dec_valid=0, queue_count=0, pc_q=RESET_PC;
//     the stale response is not pushed.
//  6. With FETCH_PERF_EN, run tests 2 and 3 -> perf_flushes=1; perf_bundles equals total pushes;
//     perf_stall_cycles equals blocked cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the N-wide fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam int unsigned MAX_FETCH_WIDTH = 4;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_JALR   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_src_t;

  // Decode-side view of one fetch group; lanes at or above FETCH_WIDTH are unused.
  typedef struct packed {
    logic [MAX_FETCH_WIDTH-1:0][31:0] pc;
    logic [MAX_FETCH_WIDTH-1:0][31:0] instr;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_unit_nw_if.sv
// Redirect, instruction-memory and decode signals of the fetch stage.
interface fetch_unit_nw_if
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 4
) ();

  logic [31:0]                  jalr_pc;
  logic [31:0]                  branch_pc;
  logic [31:0]                  jump_pc;
  pc_src_t                      pc_source;
  logic                         ld_haz;
  logic                         imem_req;
  logic [31:0]                  imem_addr;
  logic [32*FETCH_WIDTH-1:0]    imem_rdata;
  logic                         dec_valid;
  logic                         dec_ready;
  logic [32*FETCH_WIDTH-1:0]    dec_pc;
  logic [32*FETCH_WIDTH-1:0]    dec_instr;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;

  modport master (
    input  jalr_pc, branch_pc, jump_pc, pc_source, ld_haz, imem_rdata, dec_ready,
    output imem_req, imem_addr, dec_valid, dec_pc, dec_instr, queue_count
  );

  modport slave (
    output jalr_pc, branch_pc, jump_pc, pc_source, ld_haz, imem_rdata, dec_ready,
    input  imem_req, imem_addr, dec_valid, dec_pc, dec_instr, queue_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch bundles with synchronous flush; head is read from registered storage.
module fetch_queue #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_i) assert (count_q < CntW'(Depth));
  end

endmodule

// File: rtl/fetch_unit_nw.sv
// N-wide fetch stage: PC, redirect mux, credit-gated issue and response push into the queue.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_unit_nw
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic            CLK,
  input  logic            EXT_RESET,
  fetch_unit_nw_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_bundles,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int unsigned CntW       = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned LaneBits   = 32 * FETCH_WIDTH;
  localparam logic [31:0] GroupBytes = 32'(INSTR_BYTES * FETCH_WIDTH);

  logic [31:0]         pc_q, pc_d, pend_addr_q, target;
  logic                pend_q, redirect, credit_ok, issue, push, pop;
  logic [CntW-1:0]     count;
  logic [CntW:0]       in_flight;
  logic [2*LaneBits-1:0] push_data, head_data;
  logic                head_valid;

  assign redirect  = (bus.pc_source != PC_NEXT);
  assign in_flight = {1'b0, count} + (CntW + 1)'(pend_q);
  assign credit_ok = in_flight < (CntW + 1)'(QUEUE_DEPTH);
  assign issue     = !EXT_RESET && !redirect && !bus.ld_haz && credit_ok;
  // A redirect kills the response in flight and overrides any same-cycle pop.
  assign push      = pend_q && !redirect && !EXT_RESET;
  assign pop       = head_valid && bus.dec_ready && !redirect;

  always_comb begin
    target = bus.jalr_pc;
    unique case (bus.pc_source)
      PC_JALR:   target = bus.jalr_pc;
      PC_BRANCH: target = bus.branch_pc;
      PC_JUMP:   target = bus.jump_pc;
      default:   target = bus.jalr_pc;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = {target[31:2], 2'b00};
    else if (issue) pc_d = pc_q + GroupBytes;
  end

  // Low half of a bundle holds lane PCs, high half holds lane instructions.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      push_data[32*i +: 32]            = pend_addr_q + 32'(INSTR_BYTES * i);
      push_data[LaneBits + 32*i +: 32] = bus.imem_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge CLK) begin
    if (EXT_RESET) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= issue;
      if (issue) pend_addr_q <= pc_q;
    end
  end

  fetch_queue #(
    .Width (2 * LaneBits),
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (CLK),
    .rst_i       (EXT_RESET),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect),
    .valid_o     (head_valid),
    .head_o      (head_data),
    .count_o     (count)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.dec_valid   = head_valid;
  assign bus.dec_pc      = head_data[LaneBits-1:0];
  assign bus.dec_instr   = head_data[2*LaneBits-1:LaneBits];
  assign bus.queue_count = count;

`ifdef FETCH_PERF_EN
  logic [31:0] bundles_q, stalls_q, flushes_q;

  always_ff @(posedge CLK) begin
    if (EXT_RESET) begin
      bundles_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (push)                        bundles_q <= bundles_q + 32'd1;
      if (bus.ld_haz || !credit_ok)    stalls_q  <= stalls_q + 32'd1;
      if (redirect)                    flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_bundles      = bundles_q;
  assign perf_stall_cycles = stalls_q;
  assign perf_flushes      = flushes_q;
`endif

endmodule
